// File: rtl/soc_pkg.sv
// soc_pkg: shared types and sample-packing constants for the ADC capture block.
package soc_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} adc_cap_state_t;
   localparam int SMP_W   = 32;
   localparam int CH_W    = 16;
   localparam int CHA_LSB = 0;
   localparam int CHB_LSB = 16;
endpackage

// File: rtl/adc_trig_detect.sv
// adc_trig_detect: signed rising-crossing detector on one ADC channel.
//   clk, arst_n : clock, asynchronous active-low reset
//   clr_i       : forget the previous sample (no crossing until a new one is seen)
//   vld_i       : sample strobe
//   smp_i       : current channel sample (signed)
//   lvl_i       : trigger level (signed)
//   hit_o       : previous valid sample < lvl_i and current >= lvl_i
module adc_trig_detect
   import soc_pkg::*;
(
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   clr_i,
   input  logic                   vld_i,
   input  logic signed [CH_W-1:0] smp_i,
   input  logic signed [CH_W-1:0] lvl_i,
   output logic                   hit_o
);
   logic signed [CH_W-1:0] prev_q;
   logic                   pvld_q;

   assign hit_o = vld_i && pvld_q && (prev_q < lvl_i) && (smp_i >= lvl_i);

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         prev_q <= '0;
         pvld_q <= 1'b0;
      end else if (clr_i) begin
         pvld_q <= 1'b0;
      end else if (vld_i) begin
         prev_q <= smp_i;
         pvld_q <= 1'b1;
      end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: captures decimated ADC samples into a circular RAM window.
//   clk, arst_n        : ADC sample clock, asynchronous active-low reset
//   start, abort       : one-cycle pulses to arm / cancel a capture
//   cfg_base/len/decim : window start, word count (0 or >NUM_WORDS means NUM_WORDS), keep 1 in decim+1
//   smp_vld, smp_dat   : ADC sample strobe and {chB, chA} data
//   ram_we/addr/wdat   : registered RAM write port
//   busy, done, wr_cnt : status; done is sticky until the next start
//   Optional macro ADC_CAPTURE_TRIG_EN adds trig_en/trig_lvl/trig_ch level-crossing trigger.
module adc_capture_ctrl
   import soc_pkg::*;
#(
   parameter int NUM_WORDS = 8192,
   parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic [7:0]        cfg_decim,
   input  logic              smp_vld,
   input  logic [SMP_W-1:0]  smp_dat,
`ifdef ADC_CAPTURE_TRIG_EN
   input  logic              trig_en,
   input  logic [CH_W-1:0]   trig_lvl,
   input  logic              trig_ch,
`endif
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [SMP_W-1:0]  ram_wdat,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_cnt
);
   localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(NUM_WORDS);
   localparam logic [ADDR_W+1:0] NW_X    = (ADDR_W+2)'(NUM_WORDS);

   adc_cap_state_t    state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [7:0]        decim_q, decim_d;
   logic [7:0]        dcnt_q, dcnt_d;
   logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [SMP_W-1:0]  ram_wdat_q, ram_wdat_d;
   logic              acc;
   logic              arm_go;
   logic              arm_acc;
   logic [ADDR_W+1:0] sum;
   logic [ADDR_W-1:0] addr_nxt;

   // Leaving ARMED: either immediately, or on a trigger crossing whose sample is the first word.
`ifdef ADC_CAPTURE_TRIG_EN
   logic trig_hit;

   adc_trig_detect u_trig (
      .clk   (clk),
      .arst_n(arst_n),
      .clr_i (state_q != ST_ARMED),
      .vld_i (smp_vld),
      .smp_i (trig_ch ? smp_dat[CHB_LSB +: CH_W] : smp_dat[CHA_LSB +: CH_W]),
      .lvl_i (trig_lvl),
      .hit_o (trig_hit)
   );

   assign arm_go  = !trig_en || trig_hit;
   assign arm_acc = trig_en && trig_hit;
`else
   assign arm_go  = 1'b1;
   assign arm_acc = 1'b0;
`endif

   // Base + count never exceeds 2*NUM_WORDS, so one conditional subtract gives the modulo.
   assign sum      = {2'b00, base_q} + {1'b0, wr_cnt_q};
   assign addr_nxt = ADDR_W'(sum >= NW_X ? sum - NW_X : sum);

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      decim_d  = decim_q;
      dcnt_d   = dcnt_q;
      wr_cnt_d = wr_cnt_q;
      acc      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE:
            if (start && !abort) begin
               base_d   = cfg_base;
               len_d    = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
               decim_d  = cfg_decim;
               dcnt_d   = '0;
               wr_cnt_d = '0;
               state_d  = ST_ARMED;
            end
         ST_ARMED:
            if (abort) state_d = ST_IDLE;
            else if (arm_go) begin
               state_d = ST_CAPTURE;
               acc     = arm_acc;
            end
         default:
            if (abort) state_d = ST_IDLE;
            else if (smp_vld) begin
               acc    = (dcnt_q == decim_q);
               dcnt_d = acc ? 8'd0 : dcnt_q + 8'd1;
            end
      endcase
      if (acc) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         state_d  = (wr_cnt_q + 1'b1 == len_q) ? ST_DONE : ST_CAPTURE;
      end
      ram_we_d   = acc;
      ram_addr_d = acc ? addr_nxt : ram_addr_q;
      ram_wdat_d = acc ? smp_dat : ram_wdat_q;
   end

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         decim_q    <= '0;
         dcnt_q     <= '0;
         wr_cnt_q   <= '0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_wdat_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         decim_q    <= decim_d;
         dcnt_q     <= dcnt_d;
         wr_cnt_q   <= wr_cnt_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_wdat_q <= ram_wdat_d;
      end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_wdat = ram_wdat_q;
   assign busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign done     = (state_q == ST_DONE);
   assign wr_cnt   = wr_cnt_q;
endmodule
